trn_axil_reg_slave: RTL and testbench
=====================================

// Module: trn_axil_reg_slave
// PURPOSE
//  AXI4-Lite slave register bank: the responder end of the AXI4-Lite link driven by the host or master VIP.
//  Holds NUM_REGS 32-bit control/config registers for the FFT value transmitter core.
//  Exposes the registers as a flat bus and per-register write strobes.
//  Sits between the AXI interconnect and the transmitter datapath.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data width; only 32 is supported
//  C_S_AXI_ADDR_WIDTH  5   byte address width; must satisfy 2^W >= NUM_REGS*4
//  NUM_REGS            4   number of registers; power of 2, >= 2
// PORTS
//  S_AXI_ACLK     in   1        sole clock
//  S_AXI_ARESET   in   1        synchronous reset, active-high
//  S_AXI_AWADDR   in   ADDR_W   write address
//  S_AXI_AWPROT   in   3        ignored
//  S_AXI_AWVALID  in   1        write address valid
//  S_AXI_AWREADY  out  1        write address ready
//  S_AXI_WDATA    in   32       write data
//  S_AXI_WSTRB    in   4        byte enables
//  S_AXI_WVALID   in   1        write data valid
//  S_AXI_WREADY   out  1        write data ready
//  S_AXI_BRESP    out  2        write response
//  S_AXI_BVALID   out  1        write response valid
//  S_AXI_BREADY   in   1        write response ready
//  S_AXI_ARADDR   in   ADDR_W   read address
//  S_AXI_ARPROT   in   3        ignored
//  S_AXI_ARVALID  in   1        read address valid
//  S_AXI_ARREADY  out  1        read address ready
//  S_AXI_RDATA    out  32       read data
//  S_AXI_RRESP    out  2        read response
//  S_AXI_RVALID   out  1        read data valid
//  S_AXI_RREADY   in   1        read data ready
//  regs_o         out  32*N     reg k at [32k+31:32k]
//  wr_pulse_o     out  N        1-cycle strobe, reg k written
// BEHAVIOUR
//  Reset: all regs 0; AWREADY/WREADY/ARREADY 0 during reset, 1 in the cycle after reset deasserts.
//   Reset also forces BVALID, RVALID, BRESP, RRESP, RDATA and wr_pulse_o to 0.
//   Reset mid-transaction drops held AW/W and any pending B/R; no response is issued.
//  Addressing: reg index = addr[clog2(N)+1:2]; addr[1:0] ignored.
//  Write path: AW and W channels are independent; each has a 1-entry hold register.
//   AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
//   AW and W may arrive in the same cycle or in either order.
//   The write commits in the first cycle both are held (or arrive) and BVALID=0.
//    Only bytes with WSTRB set are updated.
//    wr_pulse_o[idx] pulses in the commit cycle+1, aligned with the new regs_o value.
//   BVALID rises the cycle after commit; holds, with BRESP stable, until BREADY.
//   Holds clear at commit; a new AW/W is accepted the cycle after BVALID&&BREADY.
//   WSTRB=0 still completes with OKAY but leaves the register unchanged and suppresses wr_pulse.
//  Read path: ARREADY = !RVALID.
//   On AR handshake, RDATA/RRESP are registered and RVALID=1 next cycle.
//   RDATA/RRESP hold stable until RREADY; ARREADY returns 1 the cycle after RVALID&&RREADY.
//   Read latency: 1 cycle from AR handshake to RVALID.
//  Same-cycle read and write commit to one register: the read returns the pre-write value.
//  Back-pressure: BREADY/RREADY held low indefinitely stalls only that channel.
//   Reads proceed during a stalled B, and vice versa.
// CONFIGURATION
//  TRN_AXIL_DECERR_EN defined: an address >= NUM_REGS*4 gets SLVERR (2'b10).
//   Out-of-range writes are dropped (no reg change, no wr_pulse).
//   Out-of-range reads return RDATA=0.
//  Not defined: index uses the low address bits only, so out-of-range addresses alias (wrap modulo N).
//   BRESP/RRESP are always OKAY (2'b00).
// TESTING
//  Write 1,2,3,4 to 0x0,0x4,0x8,0xC, strb=F.
//   -> 4 BRESP=OKAY; reads return 1,2,3,4; wr_pulse_o=1,2,4,8 in turn.
//  Writes with W sent 3 cycles before AW, then AW 2 cycles before W.
//   -> each commits once; BVALID is 1 cycle after the later handshake.
//  Write 0xAABBCCDD to 0x4 with WSTRB=4'b0101 over 0x02000000 (reg1 already 0x02000000).
//   -> reg1 = 0x02BB00DD.
//  BREADY low 10 cycles while reading 0x0.
//   -> read completes; BVALID stays high, BRESP stable; AWREADY=WREADY=0 throughout.
//  Write 0x55 to 0x14.
//   -> with macro: BRESP=2'b10, regs unchanged; read 0x14 gives RDATA=0, RRESP=2'b10.
//   -> without macro: reg1=0x55, OKAY.
//  Assert S_AXI_ARESET with BVALID and RVALID high.
//   -> next cycle: all valids 0, regs 0; a fresh write to 0x0 completes normally.

Source files
------------

// File: rtl/trn_axil_reg_slave.sv
// rtl/trn_axil_reg_slave.sv - AXI4-Lite register bank for the FFT value transmitter.
// Define TRN_AXIL_DECERR_EN to answer out-of-range addresses with SLVERR instead of aliasing.
module trn_axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]                    wr_pulse_o
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int NB    = DW / 8;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [NUM_REGS-1:0][DW-1:0] regs_q;
  logic                        ready_en;

  logic             aw_held, aw_oor_q;
  logic [IDX_W-1:0] aw_idx_q;
  logic             w_held;
  logic [DW-1:0]    w_data_q;
  logic [NB-1:0]    w_strb_q;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic             aw_oor_in, ar_oor_in, wr_oor;
  logic [IDX_W-1:0] aw_idx_in, ar_idx_in, wr_idx;
  logic [DW-1:0]    wr_data;
  logic [NB-1:0]    wr_strb;

  assign aw_idx_in = S_AXI_AWADDR[IDX_W+1:2];
  assign ar_idx_in = S_AXI_ARADDR[IDX_W+1:2];

`ifdef TRN_AXIL_DECERR_EN
  localparam logic [AW:0] SPAN = (AW+1)'(NUM_REGS * 4);
  assign aw_oor_in = {1'b0, S_AXI_AWADDR} >= SPAN;
  assign ar_oor_in = {1'b0, S_AXI_ARADDR} >= SPAN;
`else
  assign aw_oor_in = 1'b0;
  assign ar_oor_in = 1'b0;
`endif

  // Prot bits, byte-lane address bits and (when aliasing) upper address bits are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Readies come up one cycle after reset is released and drop immediately when it asserts.
  assign S_AXI_AWREADY = ready_en && !S_AXI_ARESET && !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY  = ready_en && !S_AXI_ARESET && !w_held  && !S_AXI_BVALID;
  assign S_AXI_ARREADY = ready_en && !S_AXI_ARESET && !S_AXI_RVALID;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign wr_idx  = aw_held ? aw_idx_q : aw_idx_in;
  assign wr_oor  = aw_held ? aw_oor_q : aw_oor_in;
  assign wr_data = w_held  ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held  ? w_strb_q : S_AXI_WSTRB;
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs) && !S_AXI_BVALID;

  assign regs_o = regs_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) ready_en <= 1'b0;
    else              ready_en <= 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      regs_q       <= '0;
      aw_held      <= 1'b0;
      aw_oor_q     <= 1'b0;
      aw_idx_q     <= '0;
      w_held       <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      wr_pulse_o   <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
        // An all-zero strobe still completes but is not a register write.
        if (!wr_oor && wr_strb != '0) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_strb[b]) regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
          end
          wr_pulse_o[wr_idx] <= 1'b1;
        end
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= aw_idx_in;
          aw_oor_q <= aw_oor_in;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end
      if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
    end
  end

  // Sampling regs_q before the commit edge makes a colliding read return the old value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= ar_oor_in ? '0 : regs_q[ar_idx_in];
      S_AXI_RRESP  <= ar_oor_in ? RESP_SLVERR : RESP_OKAY;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trn_axil_reg_slave.sv
// tb/tb_trn_axil_reg_slave.sv - self-checking bench for trn_axil_reg_slave.
// Vector table plus response/strobe scoreboard; follows TRN_AXIL_DECERR_EN when defined.
module tb_trn_axil_reg_slave;

`ifdef TRN_AXIL_DECERR_EN
  localparam bit          DECERR     = 1'b1;
  localparam logic [1:0]  OOR_RESP   = 2'b10;
  localparam logic [31:0] OOR_RD     = 32'h0;
  localparam logic [31:0] REG1_AFTER = 32'h02BB00DD;
`else
  localparam bit          DECERR     = 1'b0;
  localparam logic [1:0]  OOR_RESP   = 2'b00;
  localparam logic [31:0] OOR_RD     = 32'h55;
  localparam logic [31:0] REG1_AFTER = 32'h55;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic         bready = 1'b1, rready = 1'b1;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] regs_o;
  logic [3:0]   wr_pulse_o;

  always #5 clk = ~clk;

  trn_axil_reg_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  typedef struct {
    bit          is_rd;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  typedef struct {
    logic [3:0]  pulse;
    int          idx;
    logic [31:0] val;
  } pexp_t;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  pexp_t       exp_p[$];
  logic [31:0] model_regs [4] = '{default: 32'h0};
  vec_t        tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not within bound", name);
  endtask

  // Scoreboard: every response and strobe the DUT emits must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected");
        else check("bresp", {30'h0, bresp}, {30'h0, exp_b.pop_front()});
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) fail_now("r_unexpected");
        else begin
          logic [33:0] e;
          e = exp_r.pop_front();
          check("rdata", rdata, e[33:2]);
          check("rresp", {30'h0, rresp}, {30'h0, e[1:0]});
        end
      end
      if (wr_pulse_o !== 4'h0) begin
        if (exp_p.size() == 0) fail_now("pulse_unexpected");
        else begin
          pexp_t p;
          p = exp_p.pop_front();
          check("wr_pulse", {28'h0, wr_pulse_o}, {28'h0, p.pulse});
          check("regs_o_at_pulse", regs_o[32*p.idx +: 32], p.val);
        end
      end
    end
  end

  task automatic push_write_exp(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                                input logic [1:0] resp, input bit want_b);
    int idx;
    bit oor;
    pexp_t p;
    idx = int'(a[3:2]);
    oor = DECERR && (a >= 5'd16);
    if (want_b) exp_b.push_back(resp);
    if (!oor && s != 4'h0) begin
      for (int b = 0; b < 4; b++) if (s[b]) model_regs[idx][8*b +: 8] = d[8*b +: 8];
      p.pulse = 4'b0001 << idx;
      p.idx   = idx;
      p.val   = model_regs[idx];
      exp_p.push_back(p);
    end
  endtask

  // Write with AW/W valid raised aw_dly/w_dly cycles after start; called #1 after a posedge.
  task automatic write_skew(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp, input int aw_dly, input int w_dly);
    bit aw_done, w_done;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    push_write_exp(a, d, s, resp, 1'b1);
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && n < 50) begin
      if (!aw_done) awvalid = (n >= aw_dly);
      if (!w_done)  wvalid  = (n >= w_dly);
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      if (aw_done && w_done) check("b_early", {31'h0, bvalid}, 32'h0);
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) fail_now("write_handshake");
    @(negedge clk);
    check("b_latency", {31'h0, bvalid}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] d, input logic [1:0] r);
    bit done;
    int n;
    done = 0; n = 0;
    exp_r.push_back({d, r});
    araddr = a; arvalid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      if (arready) done = 1;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 1'b0;
    if (!done) fail_now("ar_handshake");
    @(negedge clk);
    check("r_latency", {31'h0, rvalid}, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 5'h00, 32'h1,        4'hF, 2'b00};
    tbl[1]  = '{1'b0, 5'h04, 32'h2,        4'hF, 2'b00};
    tbl[2]  = '{1'b0, 5'h08, 32'h3,        4'hF, 2'b00};
    tbl[3]  = '{1'b0, 5'h0C, 32'h4,        4'hF, 2'b00};
    tbl[4]  = '{1'b1, 5'h00, 32'h1,        4'h0, 2'b00};
    tbl[5]  = '{1'b1, 5'h04, 32'h2,        4'h0, 2'b00};
    tbl[6]  = '{1'b1, 5'h08, 32'h3,        4'h0, 2'b00};
    tbl[7]  = '{1'b1, 5'h0C, 32'h4,        4'h0, 2'b00};
    tbl[8]  = '{1'b0, 5'h04, 32'h02000000, 4'hF, 2'b00};
    tbl[9]  = '{1'b0, 5'h04, 32'hAABBCCDD, 4'h5, 2'b00};
    tbl[10] = '{1'b1, 5'h04, 32'h02BB00DD, 4'h0, 2'b00};
    tbl[11] = '{1'b0, 5'h08, 32'h12345678, 4'h0, 2'b00};
    tbl[12] = '{1'b1, 5'h08, 32'h3,        4'h0, 2'b00};
    tbl[13] = '{1'b1, 5'h02, 32'h1,        4'h0, 2'b00};
    tbl[14] = '{1'b0, 5'h14, 32'h55,       4'hF, OOR_RESP};
    tbl[15] = '{1'b1, 5'h14, OOR_RD,       4'h0, OOR_RESP};
    tbl[16] = '{1'b1, 5'h04, REG1_AFTER,   4'h0, 2'b00};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readies", {29'h0, awready, wready, arready}, 32'h0);
    check("rst_valids", {30'h0, bvalid, rvalid}, 32'h0);
    check("rst_regs_zero", {31'h0, regs_o != 128'h0}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("readies_still_low", {29'h0, awready, wready, arready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("readies_after_rst", {29'h0, awready, wready, arready}, 32'h7);
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].is_rd) axi_read(tbl[i].addr, tbl[i].data, tbl[i].resp);
      else write_skew(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp, 0, 0);
    end

    // Skewed channel arrival: W three cycles ahead, then AW two cycles ahead
    write_skew(5'h0C, 32'h44, 4'hF, 2'b00, 3, 0);
    write_skew(5'h08, 32'h33, 4'hF, 2'b00, 0, 2);
    axi_read(5'h0C, 32'h44, 2'b00);
    axi_read(5'h08, 32'h33, 2'b00);

    // B back-pressure while a read proceeds
    bready = 1'b0;
    push_write_exp(5'h00, 32'h1, 4'hF, 2'b00, 1'b1);
    awaddr = 5'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("bp_aw_w_ready", {30'h0, awready, wready}, 32'h3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    axi_read(5'h00, 32'h1, 2'b00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bp_bvalid", {31'h0, bvalid}, 32'h1);
      check("bp_bresp", {30'h0, bresp}, 32'h0);
      check("bp_aw_w_blocked", {30'h0, awready, wready}, 32'h0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release", {29'h0, bvalid, awready, wready}, 32'h3);
    @(posedge clk); #1;

    // Read and write commit to the same register in one cycle
    exp_r.push_back({model_regs[0], 2'b00});
    push_write_exp(5'h00, 32'h99, 4'hF, 2'b00, 1'b1);
    awaddr = 5'h00; araddr = 5'h00; wdata = 32'h99; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    check("rw_readies", {29'h0, awready, wready, arready}, 32'h7);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("rw_valids", {30'h0, bvalid, rvalid}, 32'h3);
    @(posedge clk); #1;

    // Reset with both responses pending
    bready = 1'b0; rready = 1'b0;
    push_write_exp(5'h04, 32'h5A, 4'hF, 2'b00, 1'b0);
    awaddr = 5'h04; araddr = 5'h08; wdata = 32'h5A; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_valids", {30'h0, bvalid, rvalid}, 32'h3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_valids", {30'h0, bvalid, rvalid}, 32'h0);
    check("mid_rst_readies", {29'h0, awready, wready, arready}, 32'h0);
    check("mid_rst_regs_zero", {31'h0, regs_o != 128'h0}, 32'h0);
    check("mid_rst_pulse", {28'h0, wr_pulse_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    @(posedge clk); #1;
    write_skew(5'h00, 32'h77, 4'hF, 2'b00, 0, 0);
    axi_read(5'h00, 32'h77, 2'b00);
    axi_read(5'h04, 32'h0, 2'b00);

    repeat (3) @(posedge clk);
    check("b_queue_empty", exp_b.size(), 32'h0);
    check("r_queue_empty", exp_r.size(), 32'h0);
    check("pulse_queue_empty", exp_p.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
